// File: rtl/vx_rsp_router_pkg.sv
// ============================================================================
// vx_rsp_router_pkg
// Shared types and helpers for the response router and its arbiter partner.
//   log2up        : index width for a client count (at least 1 bit)
//   tag_t         : requester index type for the default client count
//   OUTSTANDING_W : width of the occupancy counter for the default depth
//   idx_to_onehot : requester index to one-hot select (up to ONEHOT_MAX clients)
// ============================================================================
package vx_rsp_router_pkg;

    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int VX_NUM_REQS     = 4;
    localparam int VX_LOG_NUM_REQS = log2up(VX_NUM_REQS);
    localparam int VX_DATA_WIDTH   = 32;
    localparam int VX_DEPTH        = 8;
    localparam int OUTSTANDING_W   = $clog2(VX_DEPTH) + 1;
    localparam int ONEHOT_MAX      = 32;

    typedef logic [VX_LOG_NUM_REQS-1:0] tag_t;

    // Callers slice the low NUM_REQS bits of the result.
    function automatic logic [ONEHOT_MAX-1:0] idx_to_onehot(input logic [4:0] idx);
        logic [ONEHOT_MAX-1:0] oh;
        oh = {{(ONEHOT_MAX-1){1'b0}}, 1'b1} << idx;
        return oh;
    endfunction

endpackage

// File: rtl/vx_rsp_router_if.sv
// ============================================================================
// vx_rsp_router_if
// Bundles the allocation, shared-response and per-client response handshakes.
//   master : environment side (arbiter, memory port, clients)
//   slave  : router side
// Signals: alloc_valid/alloc_index/alloc_ready, rsp_valid/rsp_data/rsp_ready,
//          rsp_out_valid/rsp_out_data/rsp_out_ready, outstanding.
// ============================================================================
interface vx_rsp_router_if
    import vx_rsp_router_pkg::*;
#(
    parameter int NUM_REQS   = VX_NUM_REQS,
    parameter int DATA_WIDTH = VX_DATA_WIDTH,
    parameter int DEPTH      = VX_DEPTH
);
    localparam int LOG_NUM_REQS = log2up(NUM_REQS);
    localparam int CNT_W        = $clog2(DEPTH) + 1;

    logic                    alloc_valid;
    logic [LOG_NUM_REQS-1:0] alloc_index;
    logic                    alloc_ready;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic                    rsp_ready;
    logic [NUM_REQS-1:0]     rsp_out_valid;
    logic [DATA_WIDTH-1:0]   rsp_out_data;
    logic [NUM_REQS-1:0]     rsp_out_ready;
    logic [CNT_W-1:0]        outstanding;

    modport master (
        output alloc_valid, alloc_index, rsp_valid, rsp_data, rsp_out_ready,
        input  alloc_ready, rsp_ready, rsp_out_valid, rsp_out_data, outstanding
    );

    modport slave (
        input  alloc_valid, alloc_index, rsp_valid, rsp_data, rsp_out_ready,
        output alloc_ready, rsp_ready, rsp_out_valid, rsp_out_data, outstanding
    );

endinterface

// File: rtl/vx_rsp_tag_fifo.sv
// ============================================================================
// vx_rsp_tag_fifo
// In-order tag queue holding the requester index of every outstanding
// transaction. Pointers wrap modulo DEPTH (power of two).
//   clk, reset   : clock, asynchronous active-low reset
//   push, data_in: enqueue (ignored when full)
//   pop          : dequeue head (ignored when empty)
//   head         : oldest tag; a pushed tag appears here the next cycle
//   full, empty  : occupancy flags
//   count        : occupancy, 0..DEPTH
// ============================================================================
module vx_rsp_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Occupancy flags and protected push/pop strobes.
    always_comb begin
        full_s    = (count_r == CNT_W'(DEPTH));
        empty_s   = (count_r == CNT_W'(0));
        push_ok_s = push & ~full_s;
        pop_ok_s  = pop & ~empty_s;
    end

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_r  <= PTR_W'(0);
            rptr_r  <= PTR_W'(0);
            count_r <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wptr_r] <= data_in;
                wptr_r        <= wptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
            end
            // A simultaneous push and pop leaves the count unchanged.
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/vx_rsp_router.sv
// ============================================================================
// vx_rsp_router
// Records each accepted arbiter grant in an in-order tag queue and steers the
// shared in-order response stream back to the client that issued it.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : vx_rsp_router_if.slave
//                alloc_*       grant recording (alloc_ready = not full)
//                rsp_*         shared response input
//                rsp_out_*     per-client one-hot valid, broadcast data, ready
//                outstanding   tag-queue occupancy
// Build option: VX_RSP_ROUTER_OUT_BUF_EN adds a one-entry output register
// that cuts the rsp_out_ready -> rsp_ready path at the cost of one cycle.
// ============================================================================
module vx_rsp_router
    import vx_rsp_router_pkg::*;
#(
    parameter int NUM_REQS     = VX_NUM_REQS,
    parameter int LOG_NUM_REQS = log2up(NUM_REQS),
    parameter int DATA_WIDTH   = VX_DATA_WIDTH,
    parameter int DEPTH        = VX_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    vx_rsp_router_if.slave bus
);
    logic [LOG_NUM_REQS-1:0] head_s;
    logic                    full_s;
    logic                    empty_s;
    logic [$clog2(DEPTH):0]  count_s;
    logic                    alloc_fire_s;
    logic                    rsp_fire_s;
    logic                    rsp_ready_s;
    logic [ONEHOT_MAX-1:0]   onehot_full_s;
    logic [NUM_REQS-1:0]     head_onehot_s;
    logic                    unused_onehot_hi_s;

    vx_rsp_tag_fifo #(
        .WIDTH (LOG_NUM_REQS),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (alloc_fire_s),
        .data_in (bus.alloc_index),
        .pop     (rsp_fire_s),
        .head    (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    // Destination select of the head tag and the two handshake fires.
    // A full queue refuses allocs even when a pop happens in the same cycle.
    always_comb begin
        onehot_full_s = idx_to_onehot(5'(head_s));
        head_onehot_s = onehot_full_s[NUM_REQS-1:0];
        alloc_fire_s  = bus.alloc_valid & ~full_s;
        rsp_fire_s    = bus.rsp_valid & rsp_ready_s;
    end

    assign unused_onehot_hi_s = ^onehot_full_s[ONEHOT_MAX-1:NUM_REQS];
    assign bus.alloc_ready    = ~full_s;
    assign bus.rsp_ready      = rsp_ready_s;
    assign bus.outstanding    = count_s;

`ifdef VX_RSP_ROUTER_OUT_BUF_EN
    logic                  buf_valid_r;
    logic [NUM_REQS-1:0]   buf_dest_r;
    logic [DATA_WIDTH-1:0] buf_data_r;
    logic                  buf_drain_s;

    // The buffer can take a new response when empty or emptying this cycle.
    always_comb begin
        buf_drain_s = buf_valid_r & (|(buf_dest_r & bus.rsp_out_ready));
        rsp_ready_s = ~empty_s & (~buf_valid_r | buf_drain_s);
    end

    // One-entry output register holding the response and its destination.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid_r <= 1'b0;
            buf_dest_r  <= NUM_REQS'(0);
            buf_data_r  <= DATA_WIDTH'(0);
        end else if (rsp_fire_s) begin
            buf_valid_r <= 1'b1;
            buf_dest_r  <= head_onehot_s;
            buf_data_r  <= bus.rsp_data;
        end else if (buf_drain_s) begin
            buf_valid_r <= 1'b0;
            buf_dest_r  <= NUM_REQS'(0);
            buf_data_r  <= buf_data_r;
        end else begin
            buf_valid_r <= buf_valid_r;
            buf_dest_r  <= buf_dest_r;
            buf_data_r  <= buf_data_r;
        end
    end

    assign bus.rsp_out_valid = buf_dest_r & {NUM_REQS{buf_valid_r}};
    assign bus.rsp_out_data  = buf_data_r;
`else
    logic [NUM_REQS-1:0] out_valid_s;

    // Pure combinational steering of the response to the head-tag client.
    // An empty queue stalls the response rather than dropping it.
    always_comb begin
        rsp_ready_s = ~empty_s & (|(head_onehot_s & bus.rsp_out_ready));
        if (bus.rsp_valid & ~empty_s) begin
            out_valid_s = head_onehot_s;
        end else begin
            out_valid_s = NUM_REQS'(0);
        end
    end

    assign bus.rsp_out_valid = out_valid_s;
    assign bus.rsp_out_data  = bus.rsp_data;
`endif

endmodule

// File: tb/tb_vx_rsp_router.sv
// ============================================================================
// tb_vx_rsp_router
// Self-checking bench for vx_rsp_router. A queue-based reference model of the
// outstanding tags (plus a one-slot model of the output register when
// VX_RSP_ROUTER_OUT_BUF_EN is defined) predicts the handshakes every cycle.
// ============================================================================
module tb_vx_rsp_router;
    import vx_rsp_router_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int DP = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    vx_rsp_router_if #(.NUM_REQS(NR), .DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    vx_rsp_router #(
        .NUM_REQS   (NR),
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model state
    int            q_tags[$];
    bit            mb_valid;
    int            mb_dest;
    logic [DW-1:0] mb_data;
    int            exp_dest[$];
    logic [DW-1:0] exp_data[$];
    int            log_dest[$];
    logic [DW-1:0] log_data[$];
    bit            last_pop;
    bit            last_push;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit av, input int idx, input bit rv, input logic [DW-1:0] data,
                         input logic [NR-1:0] rdy);
        bus.alloc_valid   = av;
        bus.alloc_index   = tag_t'(idx);
        bus.rsp_valid     = rv;
        bus.rsp_data      = data;
        bus.rsp_out_ready = rdy;
    endtask

    task automatic clear_logs();
        exp_dest.delete();
        exp_data.delete();
        log_dest.delete();
        log_data.delete();
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        int            cnt;
        int            t;
        bit            e_ar;
        bit            e_rr;
        bit            push_f;
        bit            pop_f;
        logic [NR-1:0] e_ov;
        logic [DW-1:0] e_od;
        @(negedge clk);
        cnt  = q_tags.size();
        e_ar = (cnt != DP);
        e_rr = 1'b0;
        e_ov = '0;
`ifdef VX_RSP_ROUTER_OUT_BUF_EN
        if (cnt > 0) e_rr = !mb_valid || bus.rsp_out_ready[mb_dest];
        if (mb_valid) e_ov[mb_dest] = 1'b1;
        e_od = mb_data;
`else
        if (cnt > 0) begin
            e_rr = bus.rsp_out_ready[q_tags[0]];
            if (bus.rsp_valid) e_ov[q_tags[0]] = 1'b1;
        end
        e_od = bus.rsp_data;
`endif
        check_eq("alloc_ready", 64'(bus.alloc_ready), 64'(e_ar));
        check_eq("rsp_ready", 64'(bus.rsp_ready), 64'(e_rr));
        check_eq("rsp_out_valid", 64'(bus.rsp_out_valid), 64'(e_ov));
        check_eq("outstanding", 64'(bus.outstanding), 64'(cnt));
        if (e_ov != '0) check_eq("rsp_out_data", 64'(bus.rsp_out_data), 64'(e_od));
        for (int i = 0; i < NR; i++) begin
            if (bus.rsp_out_valid[i] && bus.rsp_out_ready[i]) begin
                log_dest.push_back(i);
                log_data.push_back(bus.rsp_out_data);
            end
        end
        push_f = bus.alloc_valid && e_ar;
        pop_f  = bus.rsp_valid && e_rr;
        @(posedge clk);
`ifdef VX_RSP_ROUTER_OUT_BUF_EN
        if (mb_valid && bus.rsp_out_ready[mb_dest]) mb_valid = 1'b0;
`endif
        if (pop_f) begin
            t = q_tags.pop_front();
            exp_dest.push_back(t);
            exp_data.push_back(bus.rsp_data);
`ifdef VX_RSP_ROUTER_OUT_BUF_EN
            mb_valid = 1'b1;
            mb_dest  = t;
            mb_data  = bus.rsp_data;
`endif
        end
        if (push_f) q_tags.push_back(int'(bus.alloc_index));
        last_pop  = pop_f;
        last_push = push_f;
        #1;
    endtask

    // Assert reset away from the clock edge, check the asynchronous effect, then release.
    task automatic do_reset(input int ncyc);
        reset = 1'b0;
        #1;
        check_eq("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
        check_eq("rst_outstanding", 64'(bus.outstanding), 64'd0);
        check_eq("rst_rsp_out_valid", 64'(bus.rsp_out_valid), 64'd0);
        check_eq("rst_rsp_ready", 64'(bus.rsp_ready), 64'd0);
`ifdef VX_RSP_ROUTER_OUT_BUF_EN
        check_eq("rst_rsp_out_data", 64'(bus.rsp_out_data), 64'd0);
`endif
        q_tags.delete();
        mb_valid = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Compare what the clients received against what the model routed.
    task automatic compare_log(input string tag);
        check_eq({tag, "_count"}, 64'(log_dest.size()), 64'(exp_dest.size()));
        for (int i = 0; i < exp_dest.size() && i < log_dest.size(); i++) begin
            check_eq({tag, "_dest"}, 64'(log_dest[i]), 64'(exp_dest[i]));
            check_eq({tag, "_data"}, 64'(log_data[i]), 64'(exp_data[i]));
        end
    endtask

    initial begin
        int            pushed;
        bit            done;
        logic [DW-1:0] d;
        logic [NR-1:0] rdy;
        int            n;

        drive(1'b0, 0, 1'b0, '0, '1);
        mb_valid = 1'b0;
        #2;

        // Reset
        do_reset(3);
        step();
        clear_logs();

        // In-order routing
        drive(1'b1, 2, 1'b0, '0, '1); step();
        drive(1'b1, 0, 1'b0, '0, '1); step();
        drive(1'b1, 3, 1'b0, '0, '1); step();
        check_eq("io_outstanding3", 64'(bus.outstanding), 64'd3);
        drive(1'b0, 0, 1'b1, 32'hA, '1); step();
        drive(1'b0, 0, 1'b1, 32'hB, '1); step();
        drive(1'b0, 0, 1'b1, 32'hC, '1); step();
        drive(1'b0, 0, 1'b0, '0, '1); step(); step();
        check_eq("io_count", 64'(log_dest.size()), 64'd3);
        if (log_dest.size() == 3) begin
            check_eq("io_dest0", 64'(log_dest[0]), 64'd2);
            check_eq("io_data0", 64'(log_data[0]), 64'hA);
            check_eq("io_dest1", 64'(log_dest[1]), 64'd0);
            check_eq("io_data1", 64'(log_data[1]), 64'hB);
            check_eq("io_dest2", 64'(log_dest[2]), 64'd3);
            check_eq("io_data2", 64'(log_data[2]), 64'hC);
        end
        check_eq("io_outstanding0", 64'(bus.outstanding), 64'd0);
        clear_logs();

        // Full boundary
        for (int i = 0; i < DP; i++) begin
            drive(1'b1, int'($urandom_range(0, NR - 1)), 1'b0, '0, '1);
            step();
        end
        check_eq("full_alloc_ready", 64'(bus.alloc_ready), 64'd0);
        check_eq("full_outstanding", 64'(bus.outstanding), 64'd8);
        drive(1'b1, 1, 1'b1, $urandom, '1);
        step();
        check_eq("full_refused_push", 64'(last_push), 64'd0);
        check_eq("full_outstanding7", 64'(bus.outstanding), 64'd7);
        drive(1'b1, 1, 1'b0, '0, '1);
        step();
        check_eq("full_ninth_accept", 64'(bus.outstanding), 64'd8);
        n = 0;
        while (q_tags.size() > 0 && n < 40) begin
            drive(1'b0, 0, 1'b1, $urandom, '1);
            step();
            n++;
        end
        drive(1'b0, 0, 1'b0, '0, '1); step(); step();
        compare_log("full");
        clear_logs();

        // Wrap-around with random gaps and random client readiness
        pushed = 0;
        done   = 1'b0;
        d      = $urandom;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (pushed == 20 && q_tags.size() == 0 && !mb_valid) begin
                done = 1'b1;
                break;
            end
            if (last_pop || !bus.rsp_valid) d = $urandom;
            for (int i = 0; i < NR; i++) rdy[i] = ($urandom_range(0, 3) != 0);
            drive((pushed < 20) && ($urandom_range(0, 1) == 1), int'($urandom_range(0, NR - 1)),
                  ($urandom_range(0, 2) != 0), d, rdy);
            step();
            if (last_push) pushed++;
        end
        check_eq("wrap_done", 64'(done), 64'd1);
        check_eq("wrap_routed", 64'(exp_dest.size()), 64'd20);
        compare_log("wrap");
        drive(1'b0, 0, 1'b0, '0, '1); step();
        clear_logs();

        // Backpressure on head tag 1
        drive(1'b1, 1, 1'b0, '0, '1); step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 0, 1'b1, 32'h55, 4'b1101);
            step();
        end
`ifndef VX_RSP_ROUTER_OUT_BUF_EN
        check_eq("bp_held_outstanding", 64'(bus.outstanding), 64'd1);
`endif
        check_eq("bp_none_delivered", 64'(log_dest.size()), 64'd0);
        drive(1'b0, 0, 1'b1, 32'h55, '1); step();
        drive(1'b0, 0, 1'b0, '0, '1); step(); step();
        check_eq("bp_count", 64'(log_dest.size()), 64'd1);
        if (log_dest.size() == 1) begin
            check_eq("bp_dest", 64'(log_dest[0]), 64'd1);
            check_eq("bp_data", 64'(log_data[0]), 64'h55);
        end
        clear_logs();

        // Empty queue: alloc and response in the same cycle
        drive(1'b1, 3, 1'b1, 32'h77, '1); step();
        check_eq("empty_no_pop", 64'(last_pop), 64'd0);
        drive(1'b0, 0, 1'b1, 32'h77, '1); step();
        drive(1'b0, 0, 1'b0, '0, '1); step(); step();
        check_eq("empty_count", 64'(log_dest.size()), 64'd1);
        if (log_dest.size() == 1) begin
            check_eq("empty_dest", 64'(log_dest[0]), 64'd3);
            check_eq("empty_data", 64'(log_data[0]), 64'h77);
        end
        clear_logs();

        // Mid-stream reset with 4 outstanding
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i, 1'b0, '0, '1);
            step();
        end
        check_eq("mid_outstanding4", 64'(bus.outstanding), 64'd4);
        drive(1'b0, 0, 1'b0, '0, '1);
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 1'b1, $urandom, '1);
            step();
        end
        check_eq("mid_no_delivery", 64'(log_dest.size()), 64'd0);
        drive(1'b0, 0, 1'b0, '0, '1); step();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vx_rsp_router.md
# vx_rsp_router

Return-path companion to the fair request arbiter. Each time the arbiter's grant is accepted downstream, the router records the winning requester index in an in-order tag queue. It then steers each returning response back to that requester. The block sits between a shared in-order memory/response port and the `NUM_REQS` clients that share it, and caps the number of outstanding transactions at `DEPTH`.

## Interface
- `NUM_REQS`, 4: number of clients; must be ≥ 2.
- `LOG_NUM_REQS`, `LOG2UP(NUM_REQS)`: width of the requester index.
- `DATA_WIDTH`, 32: response payload width.
- `DEPTH`, 8: maximum outstanding transactions; power of two, ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `alloc_valid`  in  1  arbiter grant accepted this cycle (grant_valid & grant_ready).
- `alloc_index`  in  LOG_NUM_REQS  granted requester index.
- `alloc_ready`  out  1  tag queue can accept an index.
- `rsp_valid`  in  1  shared response valid.
- `rsp_data`  in  DATA_WIDTH  shared response payload.
- `rsp_ready`  out  1  response consumed.
- `rsp_out_valid`  out  NUM_REQS  one-hot per-client response valid.
- `rsp_out_data`  out  DATA_WIDTH  response payload, broadcast to all clients.
- `rsp_out_ready`  in  NUM_REQS  per-client ready.
- `outstanding`  out  $clog2(DEPTH)+1  current tag-queue occupancy.

## Operation
- **Push.** An alloc fire (`alloc_valid & alloc_ready`) writes `alloc_index` at the write pointer. The write pointer is `$clog2(DEPTH)` bits wide and wraps modulo `DEPTH`.
- **Pop.** A response fire (`rsp_valid & rsp_ready`) pops the head. Responses return strictly in alloc order.
- **Ready rules.**
  - `alloc_ready = (outstanding != DEPTH)`. There is no full-bypass: when the queue is full, an alloc is refused even if a pop happens in the same cycle.
  - When the queue is empty, `rsp_ready = 0` and `rsp_out_valid = 0`. There is no empty-bypass: an alloc and a response in the same cycle on an empty queue leave the response waiting one cycle.
- **Counter.** `outstanding` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- **Unsolicited responses.** `rsp_valid` while the queue is empty is illegal. It is stalled (`rsp_ready = 0`), never dropped.
- **`alloc_valid` while not ready** is a caller protocol error. The index is not stored.
- **Reset state** (asserted at any time, including mid-transaction):
  - Pointers and `outstanding` clear to 0.
  - `alloc_ready = 1` (visible immediately after reset asserts).
  - `rsp_ready = 0`, `rsp_out_valid = 0`, `rsp_out_data = 0` in the buffered build.
  - Pending tags are discarded.

## Timing
- A pushed tag is visible at the head the cycle after its push.
- **Unbuffered build:**
  - `rsp_out_valid[head] = rsp_valid & !empty` and `rsp_out_data = rsp_data`, both combinational.
  - `rsp_ready = !empty & rsp_out_ready[head]`.
  - Latency is 0 cycles.
- **Buffered build:**
  - A response is registered together with its one-hot destination. Latency is 1 cycle.
  - `rsp_ready = !empty & (!buf_valid | rsp_out_ready[buf_dest])`.
  - Back-to-back responses sustain full throughput when the destination client stays ready.
- `rsp_out_valid` is always one-hot or zero.

## Configuration
- **`VX_RSP_ROUTER_OUT_BUF_EN` defined:** a one-entry output register sits between the tag lookup and the client ports. It breaks the `rsp_out_ready` → `rsp_ready` combinational path and adds 1 cycle of latency.
- **Undefined:** the pure combinational steering described for the unbuffered build. The queue behaviour is identical in both builds.

## Structure
- **Shared package `vx_rsp_router_pkg`:**
  - `tag_t` typedef (`LOG_NUM_REQS` bits).
  - A localparam for the `outstanding` width.
  - An index-to-one-hot function, also reused by the arbiter's testbench.
- **Sub-module `vx_rsp_tag_fifo`:**
  - Parameterized by width and `DEPTH`.
  - Holds the pointers, storage and count.
  - Exposes push, pop, full, empty, head and count.
- The top level holds the ready/valid steering and the optional output buffer.

## Test plan
- **Reset:** hold `reset = 0` for 3 cycles, then release → `alloc_ready = 1`, `outstanding = 0`, `rsp_out_valid = 0`, `rsp_ready = 0`.
- **In-order routing:** alloc indices 2, 0, 3, then responses 0xA, 0xB, 0xC with all clients ready → clients 2, 0, 3 receive 0xA, 0xB, 0xC respectively; `outstanding` returns to 0.
- **Full boundary** (`DEPTH = 8`):
  - 8 allocs with no responses → `alloc_ready = 0`, `outstanding = 8`.
  - A ninth alloc in the same cycle as a response pop is refused; `outstanding = 7` next cycle.
  - The ninth alloc is accepted on the following cycle.
- **Wrap-around:** 20 alloc/response pairs interleaved with random gaps → every response reaches its recorded index and the pointers wrap twice.
- **Backpressure:** head tag 1, `rsp_out_ready[1] = 0` for 5 cycles while `rsp_valid = 1` → `rsp_ready = 0` and the data is held. It transfers in the cycle ready rises (buffered build: one cycle later).
- **Empty/simultaneous:** on an empty queue, alloc index 3 and `rsp_valid` in the same cycle → `rsp_ready = 0` that cycle; the response routes to client 3 on the next cycle. A mid-stream reset with 4 outstanding → `outstanding = 0` and no `rsp_out_valid` afterwards.
